async_tx: RTL and testbench
===========================

// Module: async_tx
// PURPOSE
// - Transmit end of the 4-phase bundled-data req/ack bridge: feeds the receiving handshake controller.
// - Accepts words from the local clocked domain (valid/ready), buffers them, drives data+req, waits on ack.
// - Sits on the sender side of the bridge link; ack arrives asynchronously and is synchronized here.
// PARAMETERS
// - DW           8   data word width
// - DEPTH        4   input FIFO entries (power of 2, >=2)
// - SYNC_STAGES  2   ack synchronizer flops (>=2)
// - SETUP_CYCLES 1   clocks data is stable before req rises (bundling delay, >=1)
// - TIMEOUT      255 clocks waiting on one ack edge before err is flagged (8-bit counter)
// PORTS
// - clk       in  1   clock, all state on rising edge
// - rstn      in  1   synchronous reset, active low
// - in_data   in  DW  word to send
// - in_valid  in  1   in_data valid
// - in_ready  out 1   FIFO can accept (not full)
// - ack       in  1   acknowledge from receiver, asynchronous to clk
// - req       out 1   request to receiver, registered
// - data      out DW  bundled data, registered
// - busy      out 1   FSM not IDLE or FIFO not empty
// - err       out 1   sticky ack timeout flag
// BEHAVIOUR
// - Reset (rstn=0 at edge): req=0, data=0, err=0, FIFO empty, in_ready=1 on next cycle, busy=0, FSM=IDLE,
//   sync flops=0. Applies mid-handshake: req drops at that edge, in-flight and buffered words discarded.
// - FIFO: write on in_valid&in_ready; in_ready=!full (combinational from count). Full: in_valid ignored.
//   Simultaneous push+pop when full is not permitted (in_ready=0); when empty, pushed word is visible next cycle.
// - ack_s = ack after SYNC_STAGES flops; FSM uses ack_s only.
// - FSM (encodings in def.v):
//   IDLE   : FIFO non-empty -> data<=head, pop, cnt<=SETUP_CYCLES-1, -> SETUP.
//   SETUP  : req=0, data stable; cnt==0 -> req<=1, -> REQ_HI; else cnt--.
//   REQ_HI : wait ack_s==1 -> req<=0, -> REQ_LO.
//   REQ_LO : wait ack_s==0 -> IDLE. data held until leaving REQ_LO.
// - Latency: word accepted at edge E0 into empty FIFO with FSM IDLE -> data valid at E1, req rises at E(1+SETUP_CYCLES).
// - req falls on the edge ack_s is first seen 1; next word may load one edge after ack_s seen 0.
// - data never changes while req=1 or while in REQ_LO (bundled-data rule).
// - Timeout: wait counter clears on entering REQ_HI/REQ_LO; increments each cycle in those states;
//   reaching TIMEOUT sets err (sticky until reset); FSM keeps waiting, no abort.
// - ack_s=1 while in SETUP/IDLE (protocol violation): ignored, no state change.
// - Throughput: one word per (1+SETUP_CYCLES + 2 ack round trips) clocks minimum.
// STRUCTURE
// - def.v: FSM state localparams (IDLE/SETUP/REQ_HI/REQ_LO, 2-bit), shared with the receive side.
// - Sub-module async_tx_fifo: DEPTH x DW synchronous FIFO, push/pop/full/empty, sync active-low reset.
// - Synchronizer, FSM, setup and timeout counters inline in async_tx.
// TESTING
// - Single word: push 8'hA5 at E0, ack responder 3-cycle delay -> data=8'hA5 at E1, req=1 at E2, req=0
//   after ack_s high, busy=0 after ack_s low; exactly one req pulse.
// - Burst: push 6 words 8'h01..8'h06 back-to-back, slow responder -> in_ready=0 after 4 buffered (+1 loaded),
//   receiver captures 01..06 in order, no loss/duplication.
// - Bundling: SETUP_CYCLES=3 -> data stable 3 clocks before req rise; checker asserts data constant
//   throughout req=1 and REQ_LO.
// - Timeout: responder never raises ack -> err=1 exactly TIMEOUT clocks after entering REQ_HI; req stays 1;
//   later ack completes transfer, err remains 1.
// - Reset mid-op: rstn=0 while req=1 with 2 words queued -> next edge req=0, busy=0, in_ready=1; after release
//   with ack low, new word 8'h3C transfers normally, old words never appear.
// - Spurious ack: ack=1 while IDLE -> no req, no state change; FSM responds only after ack low then real req.

Source files
------------

// File: rtl/async_tx_pkg.sv
// Shared definitions for the transmit side of the bundled-data req/ack bridge.
// The state encoding is shared with the receive-side handshake controller.
package async_tx_pkg;

    // Handshake FSM states, 2-bit encoding shared across the bridge link
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_REQ_HI = 2'b10,
        ST_REQ_LO = 2'b11
    } tx_state_t;

    // Width of the ack wait (timeout) counter
    localparam int WAIT_CNT_W = 8;

    // True while the FSM is waiting on an ack edge from the receiver
    function automatic logic is_waiting(input tx_state_t st);
        return (st == ST_REQ_HI) || (st == ST_REQ_LO);
    endfunction

endpackage

// File: rtl/async_tx_fifo.sv
// DEPTH x DW synchronous FIFO buffering words ahead of the handshake FSM.
// Head is read combinationally so the FSM can load a word on the edge
// right after it was pushed into an empty FIFO.
module async_tx_fifo
    import async_tx_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    // Guard against overflow/underflow; callers should respect full/empty anyway
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign head    = mem_reg[rd_ptr_reg];

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/async_tx.sv
// Transmit end of the 4-phase bundled-data bridge. Buffers words from the
// local valid/ready interface, presents each on data, raises req after a
// bundling delay, and completes the 4-phase cycle on the synchronized ack.
module async_tx
    import async_tx_pkg::*;
#(
    parameter int DW           = 8,
    parameter int DEPTH        = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          ack,
    output logic          req,
    output logic [DW-1:0] data,
    output logic          busy,
    output logic          err
);

    localparam int SCW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] ack_sync_reg;
    logic                   ack_s;

    tx_state_t              state_reg;
    logic                   req_reg;
    logic [DW-1:0]          data_reg;
    logic                   err_reg;
    logic [SCW-1:0]         setup_cnt_reg;
    logic [WAIT_CNT_W-1:0]  wait_cnt_reg;

    logic [DW-1:0]          fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;
    // A word leaves the FIFO only when the FSM loads it into data
    assign fifo_pop  = (state_reg == ST_IDLE) && !fifo_empty;

    async_tx_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Multi-flop synchronizer for the asynchronous ack; only ack_s is used downstream
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ack_sync_reg <= '0;
        end else begin
            ack_sync_reg <= {ack_sync_reg[SYNC_STAGES-2:0], ack};
        end
    end

    assign ack_s = ack_sync_reg[SYNC_STAGES-1];

    // Handshake FSM with registered req/data and the setup and timeout counters
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            req_reg       <= 1'b0;
            data_reg      <= '0;
            err_reg       <= 1'b0;
            setup_cnt_reg <= '0;
            wait_cnt_reg  <= '0;
        end else begin
            // Wait counter saturates at TIMEOUT; the FSM never aborts on timeout
            if (is_waiting(state_reg) && (wait_cnt_reg != WAIT_CNT_W'(TIMEOUT))) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
            if (is_waiting(state_reg) && (wait_cnt_reg == WAIT_CNT_W'(TIMEOUT - 1))) begin
                err_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    // A stray ack_s here is a receiver protocol error and is ignored
                    if (!fifo_empty) begin
                        data_reg      <= fifo_head;
                        setup_cnt_reg <= SCW'(SETUP_CYCLES - 1);
                        state_reg     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // Hold data stable for the bundling delay before req rises
                    if (setup_cnt_reg == '0) begin
                        req_reg      <= 1'b1;
                        wait_cnt_reg <= '0;
                        state_reg    <= ST_REQ_HI;
                    end else begin
                        setup_cnt_reg <= setup_cnt_reg - 1'b1;
                    end
                end
                ST_REQ_HI: begin
                    if (ack_s) begin
                        req_reg      <= 1'b0;
                        wait_cnt_reg <= '0;
                        state_reg    <= ST_REQ_LO;
                    end
                end
                ST_REQ_LO: begin
                    // data stays untouched until the return-to-zero completes
                    if (!ack_s) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign req  = req_reg;
    assign data = data_reg;
    assign err  = err_reg;
    assign busy = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_async_tx.sv
// Directed, self-checking bench for async_tx: scoreboarded receiver model,
// bundling monitors, timeout, mid-transfer reset and spurious-ack cases.
module tb_async_tx;

    logic       clk;
    logic       rstn;

    // Main DUT (SETUP_CYCLES=1)
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ack;
    logic       req;
    logic [7:0] data;
    logic       busy;
    logic       err;

    // Second DUT for the longer bundling delay (SETUP_CYCLES=3)
    logic [7:0] in_data3;
    logic       in_valid3;
    logic       in_ready3;
    logic       ack3;
    logic       req3;
    logic [7:0] data3;
    logic       busy3;
    logic       err3;

    int         checks = 0;
    int         errors = 0;

    logic [7:0] exp_q[$];
    int         rx_count   = 0;
    bit         resp_en    = 0;
    bit         spur_ack   = 0;
    int         resp_delay = 3;
    int         req_rises  = 0;

    async_tx #(
        .DW(8), .DEPTH(4), .SYNC_STAGES(2), .SETUP_CYCLES(1), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ack(ack), .req(req), .data(data),
        .busy(busy), .err(err)
    );

    async_tx #(
        .DW(8), .DEPTH(4), .SYNC_STAGES(2), .SETUP_CYCLES(3), .TIMEOUT(255)
    ) dut3 (
        .clk(clk), .rstn(rstn), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .ack(ack3), .req(req3), .data(data3),
        .busy(busy3), .err(err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return req;
            1:       return busy;
            2:       return req3;
            3:       return busy3;
            default: return in_ready;
        endcase
    endfunction

    // Bounded wait on a DUT output; an expired budget shows up as a failed check
    task automatic wait_until(input string tag, input int sel, input logic val, input int budget);
        int n = 0;
        while (sig_of(sel) !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, sig_of(sel)}, {31'd0, val});
    endtask

    // Offer one word to the main DUT, holding valid until it is accepted
    task automatic push_word(input logic [7:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(w);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Receiver model for the main DUT: captures on req rise, acks after resp_delay
    initial begin
        int rs   = 0;
        int dcnt = 0;
        logic [7:0] exp_w;
        ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                rs  = 0;
                ack = spur_ack;
            end else if (!rstn) begin
                rs  = 0;
                ack = 1'b0;
            end else begin
                case (rs)
                    0: if (req) begin
                        if (exp_q.size() == 0) begin
                            check("rx_extra_word", 32'(exp_q.size()), 32'd1);
                        end else begin
                            exp_w = exp_q.pop_front();
                            $display("RX word %02h expected %02h", data, exp_w);
                            check("rx_data", {24'd0, data}, {24'd0, exp_w});
                        end
                        rx_count++;
                        dcnt = resp_delay;
                        rs   = 1;
                    end
                    1: if (dcnt <= 1) begin ack = 1'b1; rs = 2; end else dcnt--;
                    2: if (!req) begin dcnt = resp_delay; rs = 3; end
                    3: if (dcnt <= 1) begin ack = 1'b0; rs = 0; end else dcnt--;
                    default: rs = 0;
                endcase
            end
        end
    end

    // data must not move while req is high on the main DUT; also counts req pulses
    initial begin
        logic       req_prev = 1'b0;
        logic [7:0] held0    = '0;
        forever begin
            @(negedge clk);
            if (req === 1'b1 && req_prev !== 1'b1) begin
                held0 = data;
                req_rises++;
            end else if (req === 1'b1) begin
                check("bundle_data", {24'd0, data}, {24'd0, held0});
            end
            req_prev = req;
        end
    end

    // data3 must stay constant from req3 rise until the transfer fully completes
    initial begin
        logic       req3_prev = 1'b0;
        logic       win3      = 1'b0;
        logic [7:0] held3     = '0;
        forever begin
            @(negedge clk);
            if (req3 === 1'b1 && req3_prev !== 1'b1) begin
                held3 = data3;
                win3  = 1'b1;
            end else if (win3 && req3 === 1'b0 && busy3 === 1'b0) begin
                win3 = 1'b0;
            end
            if (win3) begin
                check("bundle3_data", {24'd0, data3}, {24'd0, held3});
            end
            req3_prev = req3;
        end
    end

    initial begin
        int base_rx;
        int base_rises;

        rstn      = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_data3  = '0;
        in_valid3 = 1'b0;
        ack3      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rstn = 1'b1;
        @(negedge clk);

        // Bundling delay on the SETUP_CYCLES=3 instance
        in_data3  = 8'hC3;
        in_valid3 = 1'b1;
        @(negedge clk);
        in_valid3 = 1'b0;
        check("s3_data_e0", {24'd0, data3}, 32'd0);
        @(negedge clk);
        check("s3_data_e1", {24'd0, data3}, 32'hC3);
        check("s3_req_e1", {31'd0, req3}, 32'd0);
        @(negedge clk);
        check("s3_req_e2", {31'd0, req3}, 32'd0);
        @(negedge clk);
        check("s3_req_e3", {31'd0, req3}, 32'd0);
        @(negedge clk);
        check("s3_req_e4", {31'd0, req3}, 32'd1);
        ack3 = 1'b1;
        wait_until("s3_req_fall", 2, 1'b0, 20);
        check("s3_data_reqlo", {24'd0, data3}, 32'hC3);
        ack3 = 1'b0;
        wait_until("s3_idle", 3, 1'b0, 20);
        check("s3_data_after", {24'd0, data3}, 32'hC3);

        // Single word with 3-cycle responder
        resp_en    = 1;
        resp_delay = 3;
        base_rises = req_rises;
        base_rx    = rx_count;
        push_word(8'hA5);
        check("sw_data_e0", {24'd0, data}, 32'd0);
        check("sw_busy_e0", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("sw_data_e1", {24'd0, data}, 32'hA5);
        check("sw_req_e1", {31'd0, req}, 32'd0);
        @(negedge clk);
        check("sw_req_e2", {31'd0, req}, 32'd1);
        wait_until("sw_req_fall", 0, 1'b0, 50);
        wait_until("sw_busy_low", 1, 1'b0, 50);
        check("sw_one_pulse", 32'(req_rises - base_rises), 32'd1);
        check("sw_rx_count", 32'(rx_count - base_rx), 32'd1);

        // Burst of six with a slow responder
        resp_delay = 6;
        base_rx    = rx_count;
        for (int i = 1; i <= 5; i++) begin
            push_word(8'(i));
        end
        check("burst_full", {31'd0, in_ready}, 32'd0);
        push_word(8'h06);
        wait_until("burst_done", 1, 1'b0, 600);
        check("burst_rx_count", 32'(rx_count - base_rx), 32'd6);
        check("burst_q_empty", 32'(exp_q.size()), 32'd0);
        check("burst_in_ready", {31'd0, in_ready}, 32'd1);

        // Ack timeout: responder silent, err at exactly TIMEOUT clocks after req rise
        resp_en = 0;
        push_word(8'h77);
        wait_until("to_req_rise", 0, 1'b1, 10);
        repeat (254) @(negedge clk);
        check("to_err_early", {31'd0, err}, 32'd0);
        @(negedge clk);
        check("to_err_set", {31'd0, err}, 32'd1);
        check("to_req_held", {31'd0, req}, 32'd1);
        base_rx = rx_count;
        resp_en    = 1;
        resp_delay = 3;
        wait_until("to_complete", 1, 1'b0, 100);
        check("to_rx_count", 32'(rx_count - base_rx), 32'd1);
        check("to_err_sticky", {31'd0, err}, 32'd1);

        // Reset in the middle of a transfer with two words queued
        resp_en = 0;
        push_word(8'hB1);
        push_word(8'hB2);
        push_word(8'hB3);
        wait_until("mr_req_high", 0, 1'b1, 10);
        check("mr_busy", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        check("mr_req", {31'd0, req}, 32'd0);
        check("mr_busy_low", {31'd0, busy}, 32'd0);
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        check("mr_data", {24'd0, data}, 32'd0);
        check("mr_err_clr", {31'd0, err}, 32'd0);
        exp_q.delete();
        rstn = 1'b1;
        @(negedge clk);
        resp_en = 1;
        base_rx = rx_count;
        push_word(8'h3C);
        wait_until("mr_new_done", 1, 1'b0, 100);
        check("mr_rx_count", 32'(rx_count - base_rx), 32'd1);
        check("mr_q_empty", 32'(exp_q.size()), 32'd0);

        // Spurious ack while idle
        resp_en  = 0;
        spur_ack = 1;
        base_rises = req_rises;
        repeat (6) @(negedge clk);
        check("sp_req", {31'd0, req}, 32'd0);
        check("sp_busy", {31'd0, busy}, 32'd0);
        check("sp_no_pulse", 32'(req_rises - base_rises), 32'd0);
        spur_ack = 0;
        repeat (4) @(negedge clk);
        resp_en = 1;
        base_rx = rx_count;
        push_word(8'h5A);
        wait_until("sp_done", 1, 1'b0, 100);
        check("sp_rx_count", 32'(rx_count - base_rx), 32'd1);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
